keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 3000, meaning clock cycles each column is driven before the rows are sampled (1 ms at 3 MHz); legal range is 4 or more.
REQ-002 Parameter RELEASE_SAMPLES, default 2, meaning the number of consecutive all-high row samples that declare a release; legal range is 1 to 15.
REQ-003 clk  input  1  system clock, 3 MHz nominal; all logic on the rising edge.
REQ-004 rst_n  input  1  reset: one clock; reset is synchronous and active-low.
REQ-005 row_n  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 col_n  output  4  column drive, active-low, exactly one bit low at all times.
REQ-007 key_pressed  output  1  raw key-down indication to the downstream debouncer.
REQ-008 row_idx  output  4  one-hot row of the held key; 4'b0000 when no key is held.
REQ-009 col_idx  output  4  one-hot column of the held key; 4'b0000 when no key is held.

Function
REQ-010 row_n SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rows_s.
REQ-011 dwell_cnt SHALL count 0..SCAN_DIV-1 and then wrap to 0; a "sample edge" is the clock edge where dwell_cnt==SCAN_DIV-1.
REQ-012 The FSM SHALL have exactly two states: SCAN and HOLD.
REQ-013 SCAN, sample edge, rows_s==4'hF: col_n rotates to the next column (1110->1101->1011->0111->1110); outputs stay unchanged.
REQ-014 SCAN, sample edge, rows_s!=4'hF: in the next cycle key_pressed=1, row_idx=one-hot of the lowest-index low row, col_idx=~col_n, and the state becomes HOLD.
REQ-015 In HOLD, col_n SHALL stay frozen on the captured column.
REQ-016 In HOLD, row_idx and col_idx SHALL stay constant while key_pressed=1.
REQ-017 HOLD, sample edge, rows_s==4'hF: rel_cnt increments.
REQ-018 HOLD, sample edge, rows_s!=4'hF: rel_cnt clears to 0; rows_s is only checked for "any row low", not which row.
REQ-019 When rel_cnt would reach RELEASE_SAMPLES: in the next cycle key_pressed=0, row_idx=0, col_idx=0, rel_cnt=0, col_n advances one column, and the state becomes SCAN.
REQ-020 Multiple low rows in the same column SHALL resolve to the lowest index (row 0 has highest priority).
REQ-021 A second key in another column while in HOLD SHALL be ignored; it is picked up only after release and rescan.
REQ-022 Rows SHALL be sampled only at sample edges; glitches between sample edges have no effect.
REQ-023 Latency from a sample edge to the output update SHALL be exactly 1 cycle.
REQ-024 Press-detect latency from the synchronized row falling SHALL be at most 4*SCAN_DIV+1 cycles.
REQ-025 All outputs SHALL be registered; no combinational path from row_n to any output.

Reset
REQ-026 While rst_n=0 at a clock edge: col_n=4'b1110, key_pressed=0, row_idx=4'b0000, col_idx=4'b0000.
REQ-027 While rst_n=0 at a clock edge: state=SCAN, dwell_cnt=0, rel_cnt=0, synchronizer flops=4'b1111.
REQ-028 Reset asserted mid-HOLD SHALL abort the hold in the same edge with no release sequence.

Structure
REQ-029 Package keypad_pkg SHALL hold the scan_state_t enum {SCAN, HOLD}, the column reset constant 4'b1110, and the default SCAN_DIV and RELEASE_SAMPLES values, shared with keypad_debouncer.
REQ-030 A sub-module sync_2ff (parameterized width, reset to all-ones) SHALL implement the row synchronizer; the FSM, counters and priority encoder stay in keypad_scanner.

Verification (SCAN_DIV=4, RELEASE_SAMPLES=2)
REQ-031 Idle, rows 4'hF for 40 cycles -> col_n cycles 1110,1101,1011,0111 with 4 cycles each; key_pressed stays 0.
REQ-032 row_n=4'b1110 while col_n=1101 -> at the next sample edge +1: key_pressed=1, row_idx=0001, col_idx=0010, col_n frozen at 1101.
REQ-033 Release (row_n=4'hF) -> key_pressed drops 1 cycle after the 2nd all-high sample edge; row_idx=col_idx=0; col_n=1011.
REQ-034 Release lasting one sample, then press again -> key_pressed stays 1 and row_idx/col_idx stay unchanged.
REQ-035 row_n=4'b0101 -> row_idx=0010; a 1-cycle low glitch between sample edges -> no press.
REQ-036 rst_n=0 for 1 cycle during HOLD -> next cycle col_n=1110, key_pressed=0, row_idx=col_idx=0.

Source files
------------

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Purpose  : Shared types and constants for the 4x4 keypad scanner and its
//            downstream debouncer.
// Contents : scan_state_t      - scanner FSM states (SCAN, HOLD)
//            COL_RESET         - column drive after reset (column 0 low)
//            DEFAULT_*         - default scanner timing parameters
//            lowest_low_row()  - one-hot of the lowest-index low row
// Revision : 1.0  initial release
// ============================================================================
package keypad_pkg;

    typedef enum logic [0:0] {
        SCAN = 1'b0,
        HOLD = 1'b1
    } scan_state_t;

    localparam logic [3:0] COL_RESET               = 4'b1110;
    localparam int         DEFAULT_SCAN_DIV        = 3000;
    localparam int         DEFAULT_RELEASE_SAMPLES = 2;

    // Row 0 has the highest priority when several rows are low together.
    function automatic logic [3:0] lowest_low_row(input logic [3:0] rows);
        logic [3:0] onehot;
        onehot = 4'b0000;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) begin
                onehot = 4'b0000;
                onehot[i] = 1'b1;
            end
        end
        return onehot;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer for a bus of independent, slowly changing
//            asynchronous inputs. Flops reset to all-ones (idle level of the
//            pulled-up keypad rows).
// Ports    : clk    in   clock
//            rst_n  in   synchronous active-low reset
//            d      in   asynchronous input bus [WIDTH]
//            q      out  synchronized bus [WIDTH]
// Revision : 1.0  initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : 4x4 matrix keypad column scanner. Drives one column low at a
//            time, samples the synchronized rows once per dwell period and
//            latches the first key found until it has been seen released for
//            RELEASE_SAMPLES consecutive samples.
// Ports    : clk          in   system clock (3 MHz nominal)
//            rst_n        in   synchronous active-low reset
//            row_n[3:0]   in   keypad rows, active-low, asynchronous
//            col_n[3:0]   out  column drive, active-low, one-hot-low
//            key_pressed  out  raw key-down flag for the debouncer
//            row_idx[3:0] out  one-hot row of held key, 0 when idle
//            col_idx[3:0] out  one-hot column of held key, 0 when idle
// Revision : 1.0  initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = DEFAULT_SCAN_DIV,
    parameter int RELEASE_SAMPLES = DEFAULT_RELEASE_SAMPLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       key_pressed,
    output logic [3:0] row_idx,
    output logic [3:0] col_idx
);

    localparam int DW = $clog2(SCAN_DIV);

    scan_state_t   state;
    logic [DW-1:0] dwell_cnt;
    logic [3:0]    rel_cnt;
    logic [3:0]    rows_s;
    logic          sample_edge;
    logic          any_row_low;
    logic [3:0]    rel_next;
    logic [3:0]    col_next;

    sync_2ff #(
        .WIDTH (4)
    ) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_n),
        .q     (rows_s)
    );

    assign sample_edge = (dwell_cnt == DW'(SCAN_DIV - 1));
    assign any_row_low = (rows_s != 4'hF);
    assign rel_next    = rel_cnt + 4'd1;
    // Rotate the single low bit towards the next higher column.
    assign col_next    = {col_n[2:0], col_n[3]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= SCAN;
            dwell_cnt   <= '0;
            rel_cnt     <= '0;
            col_n       <= COL_RESET;
            key_pressed <= 1'b0;
            row_idx     <= 4'b0000;
            col_idx     <= 4'b0000;
        end else begin
            // The dwell counter free-runs in both states so sample edges keep
            // a fixed cadence across press and release.
            dwell_cnt <= sample_edge ? '0 : dwell_cnt + DW'(1);

            if (sample_edge) begin
                unique case (state)
                    SCAN: begin
                        if (any_row_low) begin
                            state       <= HOLD;
                            key_pressed <= 1'b1;
                            row_idx     <= lowest_low_row(rows_s);
                            col_idx     <= ~col_n;
                            rel_cnt     <= '0;
                        end else begin
                            col_n <= col_next;
                        end
                    end
                    HOLD: begin
                        // Any low row counts as still held; which row is not
                        // re-examined, so the captured indices stay stable.
                        if (any_row_low) begin
                            rel_cnt <= '0;
                        end else if (rel_next == 4'(RELEASE_SAMPLES)) begin
                            state       <= SCAN;
                            key_pressed <= 1'b0;
                            row_idx     <= 4'b0000;
                            col_idx     <= 4'b0000;
                            rel_cnt     <= '0;
                            col_n       <= col_next;
                        end else begin
                            rel_cnt <= rel_next;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Purpose  : Self-checking bench for keypad_scanner (SCAN_DIV=4,
//            RELEASE_SAMPLES=2). Directed scenarios plus random row/reset
//            traffic, compared every cycle against a behavioural model that
//            tracks the scan column as an integer, the held key as a row
//            number and the synchronized rows as a two-deep delay line.
// Revision : 1.0  initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int SCAN_DIV        = 4;
    localparam int RELEASE_SAMPLES = 2;

    logic       clk;
    logic       rst_n;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       key_pressed;
    logic [3:0] row_idx;
    logic [3:0] col_idx;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state (reflects the DUT after the most recent edge)
    int         m_col;      // index of the driven column 0..3
    bit         m_holding;
    int         m_row;      // row number of the held key
    int         m_rel;      // consecutive all-high samples seen while held
    int         m_dwell;    // current dwell count
    logic [3:0] m_dly[2];   // [0] = value seen by the scanner, [1] = first stage

    keypad_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .RELEASE_SAMPLES (RELEASE_SAMPLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row_n       (row_n),
        .col_n       (col_n),
        .key_pressed (key_pressed),
        .row_idx     (row_idx),
        .col_idx     (col_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] onehot4(input int idx);
        logic [3:0] v;
        v = 4'b0000;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic model_edge(input logic r, input logic [3:0] rows);
        logic [3:0] seen;
        if (!r) begin
            m_col = 0; m_holding = 0; m_rel = 0; m_dwell = 0; m_row = 0;
            m_dly[0] = 4'hF; m_dly[1] = 4'hF;
        end else begin
            seen     = m_dly[0];
            m_dly[0] = m_dly[1];
            m_dly[1] = rows;
            if (m_dwell == SCAN_DIV - 1) begin
                if (!m_holding) begin
                    if (seen == 4'hF) begin
                        m_col = (m_col + 1) % 4;
                    end else begin
                        m_holding = 1;
                        m_rel = 0;
                        for (int i = 3; i >= 0; i--) if (!seen[i]) m_row = i;
                    end
                end else if (seen == 4'hF) begin
                    m_rel++;
                    if (m_rel == RELEASE_SAMPLES) begin
                        m_holding = 0;
                        m_rel = 0;
                        m_col = (m_col + 1) % 4;
                    end
                end else begin
                    m_rel = 0;
                end
            end
            m_dwell = (m_dwell + 1) % SCAN_DIV;
        end
    endtask

    task automatic check_model();
        check_eq("col_n", {28'd0, col_n}, {28'd0, ~onehot4(m_col)});
        check_eq("key_pressed", {31'd0, key_pressed}, {31'd0, m_holding});
        check_eq("row_idx", {28'd0, row_idx}, {28'd0, m_holding ? onehot4(m_row) : 4'b0000});
        check_eq("col_idx", {28'd0, col_idx}, {28'd0, m_holding ? onehot4(m_col) : 4'b0000});
        check_eq("col_one_low", $countones(~col_n), 1);
    endtask

    // Drive inputs for one clock, advance the model, check at the falling edge.
    task automatic tick(input logic r, input logic [3:0] rows);
        rst_n = r;
        row_n = rows;
        @(posedge clk);
        model_edge(r, rows);
        @(negedge clk);
        check_model();
    endtask

    task automatic hold_until_state(input logic [3:0] rows, input bit want, input string tag);
        for (int i = 0; i < 64 && (m_holding != want); i++) tick(1'b1, rows);
        check_eq(tag, {31'd0, m_holding}, {31'd0, want});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int r;
        int len;
        logic [3:0] pat;

        rst_n = 1'b0;
        row_n = 4'hF;
        @(negedge clk);

        // Reset state
        tick(1'b0, 4'hF);
        check_eq("rst_col_n", {28'd0, col_n}, 32'h0000_000E);
        check_eq("rst_key", {31'd0, key_pressed}, 32'd0);
        check_eq("rst_row_idx", {28'd0, row_idx}, 32'd0);
        check_eq("rst_col_idx", {28'd0, col_idx}, 32'd0);

        // Idle scan: each column low for SCAN_DIV cycles, in rotating order
        for (k = 1; k <= 40; k++) begin
            tick(1'b1, 4'hF);
            check_eq("idle_col", {28'd0, col_n}, {28'd0, ~onehot4((k / SCAN_DIV) % 4)});
            check_eq("idle_key", {31'd0, key_pressed}, 32'd0);
        end

        // Press row 0 while column 1 is driven
        for (int i = 0; i < 64 && !(m_col == 1 && m_dwell == 0); i++) tick(1'b1, 4'hF);
        check_eq("wait_col1", m_col, 1);
        for (int i = 0; i < 8; i++) tick(1'b1, 4'b1110);
        check_eq("press_key", {31'd0, key_pressed}, 32'd1);
        check_eq("press_row", {28'd0, row_idx}, 32'h1);
        check_eq("press_col", {28'd0, col_idx}, 32'h2);
        check_eq("press_coln", {28'd0, col_n}, 32'hD);

        // Full release: drops after the second all-high sample, column advances
        hold_until_state(4'hF, 1'b0, "release_wait");
        check_eq("rel_key", {31'd0, key_pressed}, 32'd0);
        check_eq("rel_row", {28'd0, row_idx}, 32'd0);
        check_eq("rel_col", {28'd0, col_idx}, 32'd0);
        check_eq("rel_coln", {28'd0, col_n}, 32'hB);

        // Release lasting one sample, then pressed again: hold persists
        hold_until_state(4'b1011, 1'b1, "bounce_press");
        pat = row_idx;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, (i < 4) ? 4'hF : 4'b1011);
            check_eq("bounce_key", {31'd0, key_pressed}, 32'd1);
            check_eq("bounce_row", {28'd0, row_idx}, {28'd0, pat});
        end
        hold_until_state(4'hF, 1'b0, "bounce_release");

        // Two rows low: lowest index wins
        hold_until_state(4'b0101, 1'b1, "multi_press");
        check_eq("multi_row", {28'd0, row_idx}, 32'h2);
        hold_until_state(4'hF, 1'b0, "multi_release");

        // Single-cycle glitch that is never seen at a sample edge
        for (int i = 0; i < 8 && m_dwell != 2; i++) tick(1'b1, 4'hF);
        tick(1'b1, 4'b0000);
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 4'hF);
            check_eq("glitch_key", {31'd0, key_pressed}, 32'd0);
        end

        // Reset during HOLD aborts immediately
        hold_until_state(4'b0111, 1'b1, "rst_hold_press");
        tick(1'b0, 4'b0111);
        check_eq("rsthold_coln", {28'd0, col_n}, 32'hE);
        check_eq("rsthold_key", {31'd0, key_pressed}, 32'd0);
        check_eq("rsthold_row", {28'd0, row_idx}, 32'd0);
        check_eq("rsthold_col", {28'd0, col_idx}, 32'd0);

        // Random traffic against the model
        for (int s = 0; s < 300; s++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                tick(1'b0, 4'($urandom));
            end else if (r < 50) begin
                len = $urandom_range(1, 20);
                for (int i = 0; i < len; i++) tick(1'b1, 4'hF);
            end else if (r < 60) begin
                tick(1'b1, 4'($urandom));
            end else begin
                pat = 4'($urandom);
                len = $urandom_range(1, 20);
                for (int i = 0; i < len; i++) tick(1'b1, pat);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
